// File: rtl/inst_buffer.sv
// Instruction buffer between fetch and dispatch: a DEPTH-entry circular queue
// that accepts up to three packets per cycle and presents the oldest three.
package inst_buffer_pkg;

    typedef struct packed {
        logic        valid;
        logic [31:0] inst;
        logic [31:0] pc;
        logic [31:0] npc;
        logic        predict_direction;
        logic [31:0] predict_pc;
    } if_id_packet_t;

endpackage

module inst_buffer
    import inst_buffer_pkg::*;
#(
    parameter int DEPTH = 8
) (
    input  logic                         clock,
    input  logic                         reset,
    input  logic                         squash,
    input  if_id_packet_t [2:0]          if_packet_in,
    input  logic [1:0]                   dis_num,
    output if_id_packet_t [2:0]          dis_packet_out,
    output logic [1:0]                   ib_space,
    output logic [$clog2(DEPTH):0]       ib_count,
    output logic                         ib_empty
);

    localparam int PW = $clog2(DEPTH);
    localparam int CW = PW + 1;

    logic [PW-1:0]  head_q, head_d;
    logic [PW-1:0]  tail_q, tail_d;
    logic [CW-1:0]  count_q, count_d;
    if_id_packet_t  mem_q [DEPTH];

    logic [1:0]     push_req;
    logic [1:0]     accepted;
    logic [1:0]     pops;
    logic [CW-1:0]  free_slots;

    // Valid slots only count while contiguous from the oldest slot (2).
    always_comb begin
        push_req = 2'd0;
        if (if_packet_in[2].valid) begin
            push_req = 2'd1;
            if (if_packet_in[1].valid) begin
                push_req = 2'd2;
                if (if_packet_in[0].valid) push_req = 2'd3;
            end
        end
    end

    assign free_slots = CW'(DEPTH) - count_q;
    assign ib_space   = (free_slots >= CW'(3)) ? 2'd3 : free_slots[1:0];
    assign ib_count   = count_q;
    assign ib_empty   = (count_q == '0);

    // Space comes from the registered count only, so a same-cycle pop never frees room.
    assign accepted = (push_req > ib_space) ? ib_space : push_req;
    assign pops     = (CW'(dis_num) > count_q) ? count_q[1:0] : dis_num;

    always_comb begin
        // NOTE: every always_comb output gets a default first so no path infers a latch.
        head_d  = head_q + PW'(pops);
        tail_d  = tail_q + PW'(accepted);
        count_d = count_q + CW'(accepted) - CW'(pops);
        if (squash) begin
            head_d  = '0;
            tail_d  = '0;
            count_d = '0;
        end
    end

    always_ff @(posedge clock or negedge reset) begin
        // NOTE: sequential state uses non-blocking assignments so all registers update together.
        if (!reset) begin
            head_q  <= '0;
            tail_q  <= '0;
            count_q <= '0;
        end else begin
            head_q  <= head_d;
            tail_q  <= tail_d;
            count_q <= count_d;
        end
    end

    // NOTE: entry storage has no reset; count alone decides which entries are visible.
    always_ff @(posedge clock) begin
        if (!squash) begin
            for (int k = 0; k < 3; k++) begin
                if (2'(k) < accepted) mem_q[tail_q + PW'(k)] <= if_packet_in[2-k];
            end
        end
    end

    always_comb begin
        for (int k = 0; k < 3; k++) begin
            dis_packet_out[2-k] = '0;
            if (CW'(k) < count_q) begin
                dis_packet_out[2-k]       = mem_q[head_q + PW'(k)];
                dis_packet_out[2-k].valid = 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_inst_buffer.sv
// Self-checking bench for inst_buffer: directed scenarios with literal expectations,
// then random traffic compared every cycle against a queue-based model.
module tb_inst_buffer;
    import inst_buffer_pkg::*;

    localparam int DEPTH = 8;

    logic                   clock;
    logic                   reset;
    logic                   squash;
    if_id_packet_t [2:0]    if_packet_in;
    logic [1:0]             dis_num;
    if_id_packet_t [2:0]    dis_packet_out;
    logic [1:0]             ib_space;
    logic [$clog2(DEPTH):0] ib_count;
    logic                   ib_empty;

    int n_compared = 0;
    int n_failed   = 0;

    inst_buffer #(.DEPTH(DEPTH)) dut (
        .clock          (clock),
        .reset          (reset),
        .squash         (squash),
        .if_packet_in   (if_packet_in),
        .dis_num        (dis_num),
        .dis_packet_out (dis_packet_out),
        .ib_space       (ib_space),
        .ib_count       (ib_count),
        .ib_empty       (ib_empty)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    task automatic check(input string name, input logic [159:0] act, input logic [159:0] exp);
        n_compared++;
        if (act !== exp) begin
            n_failed++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Reference model: the buffer is just an ordered queue of accepted packets.
    if_id_packet_t model_q[$];

    always @(posedge clock or negedge reset) begin
        if (!reset || squash) begin
            model_q.delete();
        end else begin
            int req, space, acc, npop;
            req = 0;
            while (req < 3 && if_packet_in[2-req].valid) req++;
            space = DEPTH - model_q.size();
            if (space > 3) space = 3;
            acc  = (req < space) ? req : space;
            npop = (int'(dis_num) < model_q.size()) ? int'(dis_num) : model_q.size();
            for (int i = 0; i < npop; i++) void'(model_q.pop_front());
            for (int i = 0; i < acc; i++) model_q.push_back(if_packet_in[2-i]);
        end
    end

    bit compare_en = 1'b0;

    always @(negedge clock) begin
        if (compare_en && reset) begin
            int sz, exp_space;
            sz = model_q.size();
            exp_space = (DEPTH - sz > 3) ? 3 : DEPTH - sz;
            for (int k = 0; k < 3; k++) begin
                if_id_packet_t exp_pkt;
                exp_pkt = '0;
                if (k < sz) begin
                    exp_pkt = model_q[k];
                    exp_pkt.valid = 1'b1;
                end
                check($sformatf("slot%0d", 2 - k), 160'(dis_packet_out[2-k]), 160'(exp_pkt));
            end
            check("ib_count", 160'(ib_count), 160'(sz));
            check("ib_space", 160'(ib_space), 160'(exp_space));
            check("ib_empty", 160'(ib_empty), 160'(sz == 0));
        end
    end

    function automatic if_id_packet_t make_pkt(input logic v, input logic [31:0] pc);
        if_id_packet_t p;
        p.valid             = v;
        p.inst              = $urandom;
        p.pc                = pc;
        p.npc               = pc + 32'd4;
        p.predict_direction = 1'($urandom_range(0, 1));
        p.predict_pc        = $urandom;
        return p;
    endfunction

    // valid bits given as {slot2, slot1, slot0}; slot 2 carries base_pc.
    task automatic drive(input logic [2:0] v, input logic [1:0] dn, input logic sq,
                         input logic [31:0] base_pc);
        if_packet_in[2] = make_pkt(v[2], base_pc);
        if_packet_in[1] = make_pkt(v[1], base_pc + 32'd4);
        if_packet_in[0] = make_pkt(v[0], base_pc + 32'd8);
        dis_num = dn;
        squash  = sq;
    endtask

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    initial begin
        reset = 1'b0;
        drive(3'b000, 2'd0, 1'b0, 32'h0);
        #12;
        check("rst_empty", 160'(ib_empty), 160'(1));
        check("rst_count", 160'(ib_count), 160'(0));
        check("rst_space", 160'(ib_space), 160'(3));
        check("rst_slot2", 160'(dis_packet_out[2]), 160'(0));
        @(negedge clock);
        reset = 1'b1;
        compare_en = 1'b1;

        // Three packets in order, none consumed.
        drive(3'b111, 2'd0, 1'b0, 32'h0);
        tick();
        check("push3_count", 160'(ib_count), 160'(3));
        check("push3_pc2", 160'(dis_packet_out[2].pc), 160'(32'h0));
        check("push3_pc1", 160'(dis_packet_out[1].pc), 160'(32'h4));
        check("push3_pc0", 160'(dis_packet_out[0].pc), 160'(32'h8));
        check("push3_space", 160'(ib_space), 160'(3));

        // Fill to 7, then overflow attempt, then pop 3 while full.
        drive(3'b111, 2'd0, 1'b0, 32'h10); tick();
        drive(3'b100, 2'd0, 1'b0, 32'h20); tick();
        check("fill7_count", 160'(ib_count), 160'(7));
        drive(3'b111, 2'd0, 1'b0, 32'h30); tick();
        check("full_count", 160'(ib_count), 160'(8));
        check("full_space", 160'(ib_space), 160'(0));
        drive(3'b111, 2'd3, 1'b0, 32'h40); tick();
        check("fullpop_count", 160'(ib_count), 160'(5));

        // Pop to head=6,count=2, then push 3 while popping 2: tail wraps.
        drive(3'b000, 2'd3, 1'b0, 32'h50); tick();
        check("pop_count2", 160'(ib_count), 160'(2));
        drive(3'b111, 2'd2, 1'b0, 32'h100); tick();
        check("wrap_count", 160'(ib_count), 160'(3));
        check("wrap_pc2", 160'(dis_packet_out[2].pc), 160'(32'h100));
        check("wrap_pc1", 160'(dis_packet_out[1].pc), 160'(32'h104));
        check("wrap_pc0", 160'(dis_packet_out[0].pc), 160'(32'h108));

        // Over-pop from count 2, then a non-contiguous valid pattern.
        drive(3'b000, 2'd1, 1'b0, 32'h0); tick();
        drive(3'b000, 2'd3, 1'b0, 32'h0); tick();
        check("overpop_count", 160'(ib_count), 160'(0));
        check("overpop_empty", 160'(ib_empty), 160'(1));
        drive(3'b101, 2'd0, 1'b0, 32'h200); tick();
        check("gap_count", 160'(ib_count), 160'(1));
        check("gap_slot1_valid", 160'(dis_packet_out[1].valid), 160'(0));

        // Squash at count 5 overrides push and pop.
        drive(3'b111, 2'd0, 1'b0, 32'h300); tick();
        drive(3'b100, 2'd0, 1'b0, 32'h310); tick();
        check("presquash_count", 160'(ib_count), 160'(5));
        drive(3'b111, 2'd2, 1'b1, 32'h320); tick();
        check("squash_count", 160'(ib_count), 160'(0));
        check("squash_valid2", 160'(dis_packet_out[2].valid), 160'(0));

        // Asynchronous reset between edges at count 4.
        drive(3'b111, 2'd0, 1'b0, 32'h400); tick();
        drive(3'b100, 2'd0, 1'b0, 32'h410); tick();
        check("prereset_count", 160'(ib_count), 160'(4));
        drive(3'b000, 2'd0, 1'b0, 32'h0);
        #1 reset = 1'b0;
        #1;
        check("async_count", 160'(ib_count), 160'(0));
        check("async_valid2", 160'(dis_packet_out[2].valid), 160'(0));
        #1 reset = 1'b1;
        drive(3'b100, 2'd0, 1'b0, 32'h500); tick();
        check("postreset_count", 160'(ib_count), 160'(1));

        // Random traffic: first phase drains slowly so the buffer runs full.
        for (int cyc = 0; cyc < 3000; cyc++) begin
            logic [1:0] dn;
            dn = (cyc < 1500) ? 2'($urandom_range(0, 1)) : 2'($urandom_range(0, 3));
            drive(3'($urandom_range(0, 7)), dn, ($urandom_range(0, 40) == 0),
                  32'($urandom) & 32'hFFFF_FFFC);
            tick();
            if ($urandom_range(0, 299) == 0) begin
                #2 reset = 1'b0;
                #1;
                check("rand_async_count", 160'(ib_count), 160'(0));
                reset = 1'b1;
            end
        end

        compare_en = 1'b0;
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_compared, n_failed);
        $finish;
    end

endmodule

// File: doc/inst_buffer.md
INST_BUFFER -- requirements
Module: inst_buffer

Interface
REQ-001 The block SHALL have parameter DEPTH, default 8, meaning number of buffered IF_ID_PACKET entries; legal values are powers of 2 that are at least 4.
REQ-002 The block SHALL have one clock and asynchronous active-low reset; ports in order:
- clock  input  1  sole clock, rising edge.
- reset  input  1  asynchronous active-low reset.
- squash  input  1  mispredict/precise-state flush.
- if_packet_in  input  IF_ID_PACKET[2:0]  packets from fetch; slot 2 oldest; valid slots contiguous from slot 2 downward.
- dis_num  input  2  count of output slots consumed by dispatch this cycle, oldest first (0-3).
- dis_packet_out  output  IF_ID_PACKET[2:0]  oldest up-to-3 entries to dispatch; slot 2 oldest.
- ib_space  output  2  min(3, DEPTH-count), for fetch throttling.
- ib_count  output  $clog2(DEPTH)+1  occupied entries.
- ib_empty  output  1  count==0.

Function
REQ-003 Storage SHALL be a circular array of DEPTH IF_ID_PACKET entries with registered head, tail ($clog2(DEPTH) bits, modulo-DEPTH wrap) and count registers.
REQ-004 push_req SHALL be the number of valid if_packet_in slots counted contiguously from slot 2; any valid bit below an invalid slot SHALL be ignored.
REQ-005 Accepted pushes SHALL be min(push_req, ib_space), evaluated from the registered count; same-cycle pops SHALL NOT create push space.
REQ-006 Accepted packets SHALL be written at tail, tail+1, tail+2 (mod DEPTH) in order slot 2, 1, 0; non-accepted packets SHALL be dropped silently.
REQ-007 dis_packet_out slot 2-k, for k=0..2, SHALL be combinational from registers: entry head+k with valid=1 when k<count; otherwise all fields zero and valid=0.
REQ-008 Pops SHALL be min(dis_num, count); head advances by pops mod DEPTH; entries beyond count are never consumed.
REQ-009 Next count SHALL equal count + accepted - pops; count SHALL never exceed DEPTH or go below 0.
REQ-010 Simultaneous push and pop in one cycle SHALL both take effect; at count==DEPTH with pops=3, accepted pushes SHALL be 0 that cycle.
REQ-011 When squash=1 at a rising edge, head, tail and count SHALL become 0 and that cycle's pushes and pops SHALL be ignored; squash has priority over all other inputs.
REQ-012 Entry storage need not be cleared on squash or reset; visibility is governed only by count.
REQ-013 Outputs SHALL have zero-cycle latency from register state: a packet pushed at edge N is visible on dis_packet_out after edge N (not before).
REQ-014 ib_space, ib_count and ib_empty SHALL derive only from registered count.
REQ-015 The block SHALL NOT interpret predict_direction or inst fields; slot truncation on taken branches is a downstream responsibility.

Reset
REQ-016 While reset=0, asynchronously: head=0, tail=0, count=0; hence ib_empty=1, ib_count=0, ib_space=3, all dis_packet_out valid=0 with zero fields.
REQ-017 Reset asserted mid-operation SHALL discard all contents immediately without waiting for a clock edge; the first edge after deassertion SHALL behave as a normal cycle.

Verification
REQ-018 Reset, push 3 valid (PC 0x0,0x4,0x8), dis_num=0 -> next cycle count=3, slot2.PC=0x0, slot1.PC=0x4, slot0.PC=0x8, ib_space=3.
REQ-019 DEPTH=8, count=7, push 3 -> only slot 2 accepted, count=8, ib_space=0; next cycle push 3 with dis_num=3 -> count=5, no push accepted.
REQ-020 head=6, count=2, push 3 with dis_num=2 -> tail wraps to 3 (mod 8), count=3, outputs show the three new packets in order.
REQ-021 count=2, dis_num=3 -> pops=2, count=0, ib_empty=1; if_packet_in valid pattern {1,0,1} -> only slot 2 accepted.
REQ-022 count=5, push 3, dis_num=2, squash=1 -> next cycle count=0, head=tail=0, all outputs invalid.
REQ-023 count=4, assert reset between edges -> outputs invalid and ib_count=0 before the next edge; after deassertion, a push of 1 yields count=1.
